// File: rtl/sdes_hex_display.sv
// Two-digit multiplexed hex display for an 8-bit S-DES result.
// It captures a byte on DataValid, scans the left and right digits using a
// prescaler, and drives active-low segments and anodes from registers.
module sdes_hex_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [0:7] DataOutBlock,
    input  logic       DataValid,
    input  logic       Blank,
    output logic [0:6] Segments,
    output logic [0:1] Anodes,
    output logic [0:7] ShownValue,
    output logic       Updated
);

    localparam int             CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  TC   = CW'(REFRESH_DIV - 1);
    localparam logic [0:6]     DASH = 7'b1111110;
    localparam logic [0:6]     DARK = 7'b1111111;

    typedef enum logic {EMPTY, SHOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [0:7]      shown_q, shown_d;
    logic            upd_q, upd_d;
    logic [0:6]      seg_q, seg_d;
    logic [0:1]      an_q, an_d;
    logic            tc;
    logic [3:0]      nib;

    // Active-low abcdefg pattern for a hex nibble
    function automatic logic [0:6] hex7(input logic [3:0] v);
        logic [0:6] p;
        case (v)
            4'h0: p = 7'b0000001;
            4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;
            4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;
            4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;
            4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;
            4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;
            default: p = 7'b0111000;
        endcase
        return p;
    endfunction

    // State register plus datapath registers; reset wins over every input
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            shown_q <= 8'h00;
            upd_q   <= 1'b0;
            seg_q   <= DASH;
            an_q    <= 2'b01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            shown_q <= shown_d;
            upd_q   <= upd_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Next-state, capture, scan and display decode.
    // Segments and anodes both use the next digit select, so they always agree.
    always_comb begin
        state_d = state_q;
        shown_d = shown_q;
        upd_d   = 1'b0;
        if (DataValid) begin
            state_d = SHOW;
            shown_d = DataOutBlock;
            upd_d   = (state_q == EMPTY) || (DataOutBlock != shown_q);
        end

        tc    = (cnt_q == TC);
        cnt_d = tc ? '0 : cnt_q + CW'(1);
        sel_d = sel_q ^ tc;

        nib = sel_d ? shown_q[4:7] : shown_q[0:3];

        if (Blank) begin
            seg_d = DARK;
            an_d  = 2'b11;
        end else begin
            seg_d = (state_q == EMPTY) ? DASH : hex7(nib);
            an_d  = sel_d ? 2'b10 : 2'b01;
        end
    end

    assign Segments   = seg_q;
    assign Anodes     = an_q;
    assign ShownValue = shown_q;
    assign Updated    = upd_q;

endmodule

// File: tb/tb_sdes_hex_display.sv
// Bench for sdes_hex_display with REFRESH_DIV=4.
// The reference model counts edges since reset to find the scanned digit, and
// it tracks the captured byte as a plain value.
module tb_sdes_hex_display;

    localparam int DIV = 4;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] DARK = 7'b1111111;
    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [0:7] DataOutBlock = 8'h00;
    logic       DataValid = 1'b0;
    logic       Blank = 1'b0;
    logic [0:6] Segments;
    logic [0:1] Anodes;
    logic [0:7] ShownValue;
    logic       Updated;

    sdes_hex_display #(.REFRESH_DIV(DIV)) dut (
        .CLK(CLK), .RST_N(RST_N), .DataOutBlock(DataOutBlock),
        .DataValid(DataValid), .Blank(Blank), .Segments(Segments),
        .Anodes(Anodes), .ShownValue(ShownValue), .Updated(Updated));

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int         n = 0;
    logic       m_have = 1'b0;
    logic [7:0] m_shown = 8'h00;
    logic [6:0] e_seg = DASH;
    logic [1:0] e_an = 2'b01;
    logic       e_upd = 1'b0;

    // Expected output bundle {Segments, Anodes, ShownValue, Updated}
    function automatic logic [17:0] expv();
        return {e_seg, e_an, m_shown, e_upd};
    endfunction

    // Apply inputs for one edge, advance the model, then wait until just after the edge
    task automatic tick(input logic dv, input logic [7:0] d, input logic bl, input logic rn);
        int sel;
        logic [3:0] nib;
        DataValid = dv; DataOutBlock = d; Blank = bl; RST_N = rn;
        if (!rn) begin
            n = 0; m_have = 1'b0; m_shown = 8'h00; e_upd = 1'b0;
            e_an = 2'b01; e_seg = DASH;
        end else begin
            n++;
            sel   = (n / DIV) % 2;
            nib   = (sel == 1) ? m_shown[3:0] : m_shown[7:4];
            e_seg = bl ? DARK : (m_have ? HEX[nib] : DASH);
            e_an  = bl ? 2'b11 : ((sel == 1) ? 2'b10 : 2'b01);
            e_upd = dv && (!m_have || d != m_shown);
            if (dv) begin m_shown = d; m_have = 1'b1; end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'hFF, 1'b1, 1'b0);
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== {DASH, 2'b01, 8'h00, 1'b0}) begin
                fails++;
                $display("FAIL reset cyc%0d: got %b/%b/%h/%b want 1111110/01/00/0",
                         i, Segments, Anodes, ShownValue, Updated);
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 8'($urandom), 1'b0, 1'b1);
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL idle cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
        end
    endtask

    task automatic test_capture();
        int pulses = 0;
        tick(1'b1, 8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL capture cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
            if (Updated === 1'b1) pulses++;
            tick(1'b0, 8'h00, 1'b0, 1'b1);
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL capture pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 10) tick(1'b1, 8'h3C, 1'b0, 1'b1);
            else        tick(1'b1, 8'hF0, 1'b0, 1'b1);
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL b2b cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
            if (Updated === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL b2b pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_blank();
        tick(1'b1, 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 8'h00, (i < 6), 1'b1);
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL blank cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
        end
    endtask

    task automatic test_tc_capture();
        int guard = 0;
        while ((n % DIV) != DIV - 1 && guard < 2 * DIV) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            guard++;
        end
        tick(1'b1, 8'h7E, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL tc_capture cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
            tick(1'b0, 8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'hFF, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h12, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL reset_mid cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
            tick(1'b0, 8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] last = 8'h00;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 1) == 0) ? last : 8'($urandom);
            last = d;
            tick($urandom_range(0, 2) == 0, d, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) != 0);
            checks++;
            if ({Segments, Anodes, ShownValue, Updated} !== expv()) begin
                fails++;
                $display("FAIL random cyc%0d: got %b/%b/%h/%b want %b",
                         i, Segments, Anodes, ShownValue, Updated, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_capture();
        test_back_to_back();
        test_blank();
        test_tc_capture();
        test_reset_mid();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
